// File: rtl/mem_access_sequencer_pkg.sv
// mas_pkg: state encoding, lane constants and wait-counter sizing for mem_access_sequencer
package mas_pkg;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ISSUE1 = 3'd1;
  localparam logic [2:0] ST_WAIT1  = 3'd2;
  localparam logic [2:0] ST_ISSUE2 = 3'd3;
  localparam logic [2:0] ST_WAIT2  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    ISSUE1 = ST_ISSUE1,
    WAIT1  = ST_WAIT1,
    ISSUE2 = ST_ISSUE2,
    WAIT2  = ST_WAIT2,
    DONE   = ST_DONE
  } state_t;
  localparam logic BANK_EVEN = 1'b0;
  localparam logic BANK_ODD  = 1'b1;
  localparam int RD_LAT_MAX = 4;
  localparam int CNT_W = $clog2(RD_LAT_MAX);
endpackage

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: sequences byte/word accesses onto an even/odd byte bank pair
module mem_access_sequencer
  import mas_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              mas_clk,
  input  logic              mas_rst_n,
  input  logic              mas_req,
  output logic              mas_ready,
  input  logic [ADDR_W-1:0] mas_addr,
  input  logic              mas_word,
  input  logic              mas_wr,
  input  logic [15:0]       mas_wdata,
  output logic [15:0]       mas_rdata,
  output logic              mas_done,
  output logic [ADDR_W-2:0] mas_bank_addr,
  output logic              mas_b0_rd_en,
  output logic              mas_b0_wr_en,
  output logic              mas_b1_rd_en,
  output logic              mas_b1_wr_en,
  output logic [7:0]        mas_b0_wdata,
  output logic [7:0]        mas_b1_wdata,
  input  logic [7:0]        mas_b0_rdata,
  input  logic [7:0]        mas_b1_rdata
);
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic              r_word, r_wr, r_split;
  logic [7:0]        r_wlo, r_hi, r_b0_wdata, r_b1_wdata;
  logic [15:0]       r_rdata;
  logic [ADDR_W-2:0] r_bank_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_last, w_e0, w_e1, w_accept, w_to_issue2;
  assign w_last      = r_cnt == '0;
  assign w_accept    = (r_state == IDLE) && mas_req;
  assign w_to_issue2 = (w_next == ISSUE2) && (r_state != ISSUE2);
  // state register
  always_ff @(posedge mas_clk or negedge mas_rst_n)
    if (!mas_rst_n) r_state <= IDLE;
    else r_state <= w_next;
  // next state and per-phase bank lane selection
  always_comb begin
    w_next = r_state;
    w_e0   = 1'b0;
    w_e1   = 1'b0;
    case (r_state)
      IDLE:   w_next = mas_req ? ISSUE1 : IDLE;
      ISSUE1: begin
        w_e0   = r_addr[0] == BANK_EVEN;
        w_e1   = r_word || r_addr[0] == BANK_ODD;
        w_next = !r_wr ? WAIT1 : r_split ? ISSUE2 : DONE;
      end
      WAIT1:  w_next = !w_last ? WAIT1 : r_split ? ISSUE2 : DONE;
      ISSUE2: begin
        w_e0   = 1'b1;
        w_next = r_wr ? DONE : WAIT2;
      end
      WAIT2:  w_next = w_last ? DONE : WAIT2;
      default: w_next = IDLE;
    endcase
  end
  // request capture, bank row/wdata staging, wait counter and read-lane assembly
  always_ff @(posedge mas_clk or negedge mas_rst_n)
    if (!mas_rst_n) begin
      r_addr      <= '0;
      r_word      <= 1'b0;
      r_wr        <= 1'b0;
      r_split     <= 1'b0;
      r_wlo       <= '0;
      r_hi        <= '0;
      r_b0_wdata  <= '0;
      r_b1_wdata  <= '0;
      r_rdata     <= '0;
      r_bank_addr <= '0;
      r_cnt       <= '0;
    end else begin
      if (w_accept) begin
        r_addr      <= mas_addr;
        r_word      <= mas_word;
        r_wr        <= mas_wr;
        r_split     <= mas_word & mas_addr[0];
        r_wlo       <= mas_wdata[7:0];
        r_bank_addr <= mas_addr[ADDR_W-1:1];
        if (mas_wr && mas_addr[0] == BANK_EVEN) r_b0_wdata <= mas_word ? mas_wdata[15:8] : mas_wdata[7:0];
        if (mas_wr && (mas_word || mas_addr[0] == BANK_ODD)) r_b1_wdata <= (mas_word && mas_addr[0]) ? mas_wdata[15:8] : mas_wdata[7:0];
      end
      if (w_to_issue2) begin
        r_bank_addr <= r_addr[ADDR_W-1:1] + (ADDR_W-1)'(1);
        if (r_wr) r_b0_wdata <= r_wlo;
      end
      r_cnt <= (r_state == ISSUE1 || r_state == ISSUE2) ? CNT_W'(RD_LAT - 1) : w_last ? r_cnt : r_cnt - 1'b1;
      if (r_state == WAIT1 && w_last) begin
        if (r_split) r_hi <= mas_b1_rdata;
        else r_rdata <= r_word ? {mas_b0_rdata, mas_b1_rdata} : {8'h00, r_addr[0] == BANK_ODD ? mas_b1_rdata : mas_b0_rdata};
      end
      if (r_state == WAIT2 && w_last) r_rdata <= {r_hi, mas_b0_rdata};
    end
  assign mas_ready     = r_state == IDLE;
  assign mas_done      = r_state == DONE;
  assign mas_rdata     = r_rdata;
  assign mas_bank_addr = r_bank_addr;
  assign mas_b0_wdata  = r_b0_wdata;
  assign mas_b1_wdata  = r_b1_wdata;
  assign mas_b0_rd_en  = w_e0 & ~r_wr;
  assign mas_b0_wr_en  = w_e0 & r_wr;
  assign mas_b1_rd_en  = w_e1 & ~r_wr;
  assign mas_b1_wr_en  = w_e1 & r_wr;
endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb_mem_access_sequencer: scoreboard bench against a flat byte-addressed reference memory
module tb_mem_access_sequencer;
  localparam int RL = 3;
  logic clk = 1'b0, rst_n = 1'b1, req = 1'b0, word = 1'b0, wr = 1'b0;
  logic [15:0] addr = '0, wdata = '0;
  logic ready, done, b0r, b0w, b1r, b1w;
  logic [15:0] rdata;
  logic [14:0] bank_addr;
  logic [7:0] b0_wdata, b1_wdata, b0_rdata, b1_rdata;
  always #5 clk = ~clk;
  mem_access_sequencer #(.ADDR_W(16), .RD_LAT(RL)) dut (
    .mas_clk(clk), .mas_rst_n(rst_n), .mas_req(req), .mas_ready(ready),
    .mas_addr(addr), .mas_word(word), .mas_wr(wr), .mas_wdata(wdata),
    .mas_rdata(rdata), .mas_done(done), .mas_bank_addr(bank_addr),
    .mas_b0_rd_en(b0r), .mas_b0_wr_en(b0w), .mas_b1_rd_en(b1r), .mas_b1_wr_en(b1w),
    .mas_b0_wdata(b0_wdata), .mas_b1_wdata(b1_wdata),
    .mas_b0_rdata(b0_rdata), .mas_b1_rdata(b1_rdata)
  );
  logic [7:0] m0 [0:32767];
  logic [7:0] m1 [0:32767];
  logic [7:0] p0 [RL];
  logic [7:0] p1 [RL];
  logic [7:0] ref_m [0:65535];
  // bank pair: write on enable, read data emerges RL edges after the enable edge, garbage otherwise
  always @(posedge clk) begin
    if (b0w) m0[bank_addr] <= b0_wdata;
    if (b1w) m1[bank_addr] <= b1_wdata;
    p0[0] <= b0r ? m0[bank_addr] : 8'($urandom);
    p1[0] <= b1r ? m1[bank_addr] : 8'($urandom);
    for (int i = 1; i < RL; i++) begin
      p0[i] <= p0[i-1];
      p1[i] <= p1[i-1];
    end
  end
  assign b0_rdata = p0[RL-1];
  assign b1_rdata = p1[RL-1];
  typedef struct {int acc; int lat; logic rd; logic [15:0] data;} exp_t;
  typedef struct {logic r0, w0, r1, w1; logic [14:0] row; logic [7:0] d0, d1;} ev_t;
  exp_t dq[$];
  ev_t eq[$];
  exp_t mx;
  ev_t me;
  int checks = 0, errors = 0, cyc = 0, last_done_cyc = 0;
  logic [15:0] last_rd = '0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", n, a, e, $time);
    end
  endtask
  function automatic ev_t mk(input logic [15:0] b, input logic wrt, input logic [7:0] v);
    ev_t e;
    e = '{default: '0};
    e.row = b[15:1];
    if (b[0]) begin
      e.r1 = !wrt; e.w1 = wrt; e.d1 = v;
    end else begin
      e.r0 = !wrt; e.w0 = wrt; e.d0 = v;
    end
    return e;
  endfunction
  // monitor: bank-port events and completions are checked against the queued expectations
  always @(negedge clk) if (rst_n) begin
    chk("ready_vs_outstanding", ready, dq.size() == 0);
    if (b0r | b0w | b1r | b1w) begin
      if (eq.size() == 0) chk("unexpected_bank_enable", {b0r, b0w, b1r, b1w}, 0);
      else begin
        me = eq.pop_front();
        chk("bank_enables", {b0r, b0w, b1r, b1w}, {me.r0, me.w0, me.r1, me.w1});
        chk("bank_row", bank_addr, me.row);
        if (me.w0) chk("b0_wdata", b0_wdata, me.d0);
        if (me.w1) chk("b1_wdata", b1_wdata, me.d1);
      end
    end
    if (done) begin
      if (dq.size() == 0) chk("unexpected_done", done, 0);
      else begin
        mx = dq.pop_front();
        chk("latency", cyc - mx.acc + 1, mx.lat);
        if (mx.rd) begin
          chk("rdata", rdata, mx.data);
          last_rd = mx.data;
        end
      end
      last_done_cyc = cyc;
    end else chk("rdata_hold", rdata, last_rd);
  end
  task automatic op(input logic [15:0] a, input logic w, input logic wrt, input logic [15:0] d, output int acc);
    exp_t x;
    ev_t e0v, e1v;
    logic [15:0] a1;
    int t;
    @(negedge clk);
    addr = a; word = w; wr = wrt; wdata = d; req = 1'b1; t = 0;
    while (!ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    acc = 0;
    if (!ready) begin
      chk("ready_timeout", ready, 1);
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    a1 = a + 16'd1;
    x.acc = cyc;
    x.rd = !wrt;
    x.lat = wrt ? ((w && a[0]) ? 3 : 2) : ((w && a[0]) ? 3 + 2 * RL : 2 + RL);
    x.data = w ? {ref_m[a], ref_m[a1]} : {8'h00, ref_m[a]};
    dq.push_back(x);
    e0v = mk(a, wrt, w ? d[15:8] : d[7:0]);
    if (w) begin
      e1v = mk(a1, wrt, d[7:0]);
      if (!a[0]) begin
        e0v.r1 = e1v.r1; e0v.w1 = e1v.w1; e0v.d1 = e1v.d1;
        eq.push_back(e0v);
      end else begin
        eq.push_back(e0v);
        eq.push_back(e1v);
      end
    end else eq.push_back(e0v);
    if (wrt) begin
      if (w) begin
        ref_m[a] = d[15:8];
        ref_m[a1] = d[7:0];
      end else ref_m[a] = d[7:0];
    end
  endtask
  task automatic idle(input int n);
    @(negedge clk);
    req = 1'b0;
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int acc, acc2, t;
    logic [15:0] a;
    for (int i = 0; i < 32768; i++) begin
      ref_m[2*i] = 8'($urandom);
      ref_m[2*i+1] = 8'($urandom);
      m0[i] = ref_m[2*i];
      m1[i] = ref_m[2*i+1];
    end
    #1 rst_n = 1'b0;
    #1;
    chk("reset_ready", ready, 1);
    chk("reset_done", done, 0);
    chk("reset_enables", {b0r, b0w, b1r, b1w}, 0);
    chk("reset_rdata", rdata, 0);
    chk("reset_bank_addr", bank_addr, 0);
    chk("reset_wdata", {b0_wdata, b1_wdata}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    op(16'h0011, 1'b0, 1'b1, 16'h005A, acc);
    op(16'h0011, 1'b0, 1'b0, 16'h0000, acc);
    idle(1);
    op(16'h0020, 1'b1, 1'b1, 16'hBEEF, acc);
    op(16'h0020, 1'b1, 1'b0, 16'h0000, acc);
    op(16'h0031, 1'b1, 1'b1, 16'h1234, acc);
    op(16'h0031, 1'b0, 1'b0, 16'h0000, acc);
    op(16'h0032, 1'b0, 1'b0, 16'h0000, acc);
    idle(3);
    ref_m[16'hFFFF] = 8'hAA; m1[15'h7FFF] = 8'hAA;
    ref_m[16'h0000] = 8'hBB; m0[15'h0000] = 8'hBB;
    op(16'hFFFF, 1'b1, 1'b0, 16'h0000, acc);
    op(16'h0043, 1'b1, 1'b0, 16'h0000, acc);
    op(16'h0050, 1'b1, 1'b1, 16'($urandom), acc2);
    chk("busy_accept_gap", acc2 - last_done_cyc, 2);
    idle(2);
    op(16'h0041, 1'b1, 1'b0, 16'h0000, acc);
    @(posedge clk);
    #2;
    req = 1'b0;
    rst_n = 1'b0;
    dq.delete();
    eq.delete();
    last_rd = '0;
    #1;
    chk("midop_reset_enables", {b0r, b0w, b1r, b1w}, 0);
    chk("midop_reset_done", done, 0);
    chk("midop_reset_ready", ready, 1);
    chk("midop_reset_rdata", rdata, 0);
    chk("midop_reset_bank_addr", bank_addr, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    op(16'h0041, 1'b1, 1'b0, 16'h0000, acc);
    for (int i = 0; i < 150; i++) begin
      a = ($urandom_range(0, 9) == 0) ? 16'hFFFF - 16'($urandom_range(0, 1)) : 16'($urandom_range(0, 63));
      op(a, 1'($urandom), 1'($urandom), 16'($urandom), acc);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 2));
    end
    idle(0);
    t = 0;
    while ((dq.size() != 0 || eq.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain", dq.size() + eq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
